bus_txn_responder: RTL and testbench

BUS_TXN_RESPONDER -- requirements
Module: bus_txn_responder

---
 rtl/bus_txn_pkg.sv | 5 +
 rtl/bus_txn_id_fifo.sv | 49 ++++
 rtl/bus_txn_responder.sv | 89 ++++++++
 tb/tb_bus_txn_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bus_txn_pkg.sv
// bus_txn_pkg: shared transaction constants and responder FSM states, also used by the watchdog.
package bus_txn_pkg;
    localparam int WDOG_LIMIT = 5;
    typedef enum logic {IDLE, SERVE} resp_state_t;
endpackage

// File: rtl/bus_txn_id_fifo.sv
// bus_txn_id_fifo: in-order ID FIFO.
//   clk, reset (sync, active high); push/din write; pop reads the head shown on dout;
//   count/full/empty report occupancy. A push into a full FIFO or a pop from an empty one is ignored.
module bus_txn_id_fifo #(
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ID_W-1:0]              din,
    output logic [ID_W-1:0]              dout,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    logic [ID_W-1:0] mem_q [QUEUE_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;
    assign full    = count_q == (AW+1)'(QUEUE_DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Pointers are exactly log2(depth) bits wide, so they wrap modulo the depth for free.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/bus_txn_responder.sv
// bus_txn_responder: queues request IDs and completes each one after a configurable latency.
//   clk, reset (sync, active high); start_transaction/start_id request in; latency_cfg sampled at pop;
//   complete_transaction/complete_id one-cycle completion; busy, queue_full, pending_count status;
//   drop_error pulses when a request arrives at a full queue.
//   Optional macro BUS_TXN_RESP_LATENCY_CLAMP_EN clamps latency to WDOG_LIMIT-2.
module bus_txn_responder
    import bus_txn_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int ID_W        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_transaction,
    input  logic [ID_W-1:0]              start_id,
    input  logic [2:0]                   latency_cfg,
    output logic                         complete_transaction,
    output logic [ID_W-1:0]              complete_id,
    output logic                         busy,
    output logic                         queue_full,
    output logic [$clog2(QUEUE_DEPTH):0] pending_count,
    output logic                         drop_error
);
    logic                         push, pop, full, empty;
    logic [ID_W-1:0]              head_id;
    logic [$clog2(QUEUE_DEPTH):0] count;
    resp_state_t                  state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d, eff_lat;
    logic [ID_W-1:0]              cur_id_q, cur_id_d, complete_id_q, complete_id_d;
    logic                         complete_q, complete_d, drop_q, drop_d;
    // Full is judged on the count before the edge, so a same-edge pop cannot rescue a request.
    assign push = start_transaction && !full && !reset;
    assign pop  = state_q == IDLE && !empty;
    bus_txn_id_fifo #(.QUEUE_DEPTH(QUEUE_DEPTH), .ID_W(ID_W)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(start_id),
        .dout(head_id), .count(count), .full(full), .empty(empty)
    );
    always_comb begin
`ifdef BUS_TXN_RESP_LATENCY_CLAMP_EN
        eff_lat = latency_cfg > 3'(WDOG_LIMIT - 2) ? 3'(WDOG_LIMIT - 2) : latency_cfg;
`else
        eff_lat = latency_cfg;
`endif
    end
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_id_d      = cur_id_q;
        complete_d    = 1'b0;
        complete_id_d = complete_id_q;
        drop_d        = start_transaction && full;
        if (state_q == IDLE) begin
            if (!empty) begin
                state_d  = SERVE;
                cnt_d    = eff_lat;
                cur_id_d = head_id;
            end
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            state_d       = IDLE;
            complete_d    = 1'b1;
            complete_id_d = cur_id_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cur_id_q      <= '0;
            complete_q    <= 1'b0;
            complete_id_q <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_id_q      <= cur_id_d;
            complete_q    <= complete_d;
            complete_id_q <= complete_id_d;
            drop_q        <= drop_d;
        end
    end
    assign complete_transaction = complete_q;
    assign complete_id          = complete_id_q;
    assign drop_error           = drop_q;
    assign busy                 = state_q == SERVE || !empty;
    assign queue_full           = full;
    assign pending_count        = count;
endmodule

// File: tb/tb_bus_txn_responder.sv
// tb_bus_txn_responder: directed and random checks of bus_txn_responder against a timing model.
module tb_bus_txn_responder;
    localparam int DEPTH = 4;
    logic       clk = 1'b0, reset = 1'b1, start_transaction = 1'b0;
    logic [3:0] start_id = '0;
    logic [2:0] latency_cfg = '0;
    logic       complete_transaction, busy, queue_full, drop_error;
    logic [3:0] complete_id;
    logic [2:0] pending_count;

    bus_txn_responder #(.QUEUE_DEPTH(DEPTH), .ID_W(4)) dut (
        .clk(clk), .reset(reset), .start_transaction(start_transaction), .start_id(start_id),
        .latency_cfg(latency_cfg), .complete_transaction(complete_transaction),
        .complete_id(complete_id), .busy(busy), .queue_full(queue_full),
        .pending_count(pending_count), .drop_error(drop_error)
    );

    always #5 clk = ~clk;

    int cmp = 0, mis = 0;
    int e = 0, done_edge = -1, free_edge = 0, cur_id = 0;
    int q[$];
    int cmpl_edges[$], cmpl_ids[$];
    int ndrop = 0, maxp = 0, n = 0;

    function automatic int eff(input int l);
`ifdef BUS_TXN_RESP_LATENCY_CLAMP_EN
        return l > 3 ? 3 : l;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: a request popped at edge P with latency L completes at edge P+L+1,
    // and the next pop can happen no earlier than edge P+L+2.
    task automatic step(input bit st, input int id, input int lat, input bit rst);
        bit ec, ed;
        int pre, exp_id;
        ec = 0; ed = 0; exp_id = 0;
        reset = rst; start_transaction = st; start_id = 4'(id); latency_cfg = 3'(lat);
        @(posedge clk);
        #1;
        e++;
        if (rst) begin
            q.delete();
            done_edge = -1;
            free_edge = e + 1;
        end else begin
            ec = (e == done_edge);
            exp_id = cur_id;
            pre = q.size();
            ed = st && pre == DEPTH;
            if (e >= free_edge && pre > 0) begin
                cur_id = q.pop_front();
                done_edge = e + eff(lat) + 1;
                free_edge = done_edge + 1;
            end
            if (st && pre < DEPTH) q.push_back(id);
        end
        if (complete_transaction === 1'b1) begin
            cmpl_edges.push_back(e);
            cmpl_ids.push_back(int'(complete_id));
        end
        if (drop_error === 1'b1) ndrop++;
        if (int'(pending_count) > maxp) maxp = int'(pending_count);
        chk("complete", 32'(complete_transaction), 32'(ec));
        chk("drop", 32'(drop_error), 32'(ed));
        chk("pending", 32'(pending_count), 32'(q.size()));
        chk("full", 32'(queue_full), 32'(q.size() == DEPTH));
        chk("busy", 32'(busy), 32'((e < done_edge) || q.size() > 0));
        if (ec) chk("cid", 32'(complete_id), 32'(exp_id));
        if (rst) chk("cid_rst", 32'(complete_id), 32'(0));
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // latency 2, id 3: completion registered at N+4
        step(0, 0, 2, 0);
        cmpl_edges.delete(); cmpl_ids.delete();
        step(1, 3, 2, 0); n = e;
        repeat (8) step(0, 0, 2, 0);
        chk("r030_count", 32'(cmpl_edges.size()), 32'(1));
        chk("r030_edge", 32'(cmpl_edges.size() > 0 ? cmpl_edges[0] : -1), 32'(n + 4));
        chk("r030_id", 32'(cmpl_ids.size() > 0 ? cmpl_ids[0] : -1), 32'(3));
        // latency 0, ids 1,2,3 back to back: completions 2 cycles apart
        cmpl_edges.delete(); cmpl_ids.delete();
        step(1, 1, 0, 0); n = e;
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        chk("r031_count", 32'(cmpl_edges.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk("r031_edge", 32'(cmpl_edges.size() > i ? cmpl_edges[i] : -1), 32'(n + 2 + 2 * i));
            chk("r031_id", 32'(cmpl_ids.size() > i ? cmpl_ids[i] : -1), 32'(i + 1));
        end
        // latency 7: one request in service, then 5 starts; the 5th finds the queue full
        step(1, 10, 7, 0);
        step(0, 0, 7, 0);
        ndrop = 0; maxp = 0;
        for (int i = 0; i < 5; i++) step(1, 11 + i, 7, 0);
        repeat (50) step(0, 0, 7, 0);
        chk("r032_drops", 32'(ndrop), 32'(1));
        chk("r032_maxpend", 32'(maxp), 32'(4));
        // reset two cycles into a latency-5 service: no completion, then normal service
        cmpl_edges.delete(); cmpl_ids.delete();
        step(1, 5, 5, 0);
        repeat (3) step(0, 0, 5, 0);
        step(1, 9, 5, 1);
        chk("r033_rst_busy", 32'(busy), 32'(0));
        chk("r033_rst_pend", 32'(pending_count), 32'(0));
        repeat (12) step(0, 0, 5, 0);
        chk("r033_nocompl", 32'(cmpl_edges.size()), 32'(0));
        step(1, 6, 5, 0); n = e;
        repeat (12) step(0, 0, 5, 0);
        chk("r033_edge", 32'(cmpl_edges.size() > 0 ? cmpl_edges[0] : -1), 32'(n + eff(5) + 2));
        chk("r033_id", 32'(cmpl_ids.size() > 0 ? cmpl_ids[0] : -1), 32'(6));
        // latency 6 single start
        cmpl_edges.delete(); cmpl_ids.delete();
        step(1, 7, 6, 0); n = e;
        repeat (12) step(0, 0, 6, 0);
`ifdef BUS_TXN_RESP_LATENCY_CLAMP_EN
        chk("r034_edge", 32'(cmpl_edges.size() > 0 ? cmpl_edges[0] : -1), 32'(n + 5));
`else
        chk("r034_edge", 32'(cmpl_edges.size() > 0 ? cmpl_edges[0] : -1), 32'(n + 8));
`endif
        // start against a full queue on the same edge as a pop
        step(1, 1, 7, 0);
        step(0, 0, 7, 0);
        for (int i = 0; i < 4; i++) step(1, 2 + i, 7, 0);
        chk("r035_full_before", 32'(pending_count), 32'(4));
        for (int g = 0; g < 20 && e + 1 < free_edge; g++) step(0, 0, 7, 0);
        step(1, 9, 7, 0);
        chk("r035_pend", 32'(pending_count), 32'(3));
        chk("r035_drop", 32'(drop_error), 32'(1));
        repeat (50) step(0, 0, 7, 0);
        // random traffic with occasional reset
        repeat (400)
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 63) == 0);
        repeat (60) step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
